alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

- Issue-side controller that drives the clocked ALU.
- Accepts one 32-bit MIPS instruction at a time and decodes it into a 4-bit ALU operation code plus operands.
- Presents these to the ALU for exactly one cycle and captures the ALU result on the next rising edge.
- Returns the result to the register-file write port through a valid/ready handshake; sits between instruction fetch and the ALU.

## Interface
Parameters:
- DATA_W, 32, operand/result width (only 32 supported)

Ports:
- clock  in  1  system clock; this block updates on posedge, the ALU on negedge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in IDLE
- instr  in  32  MIPS instruction word
- rs_addr, rt_addr  out  5 each  register-file read addresses (from latched instr)
- rs_data, rt_data  in  32 each  register-file read data, valid during DECODE
- alu_op  out  4  ALU operation code; 4'b0000 outside EXEC
- alu_rs, alu_rt  out  32 each  ALU operands
- alu_shamt  out  5  shift amount
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- wb_valid  out  1  write-back data offered
- wb_ready  in  1  write port accepts
- wb_reg  out  5  destination register
- wb_data  out  32  latched result
- illegal  out  1  one-cycle pulse on unsupported instruction
- branch_taken  out  1  one-cycle pulse (BEQ only, see Configuration)

## Operation
FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1; on instr_valid, latch instr and go to DECODE.
- DECODE: decode opcode/funct, sample rs_data/rt_data, register alu_op/operands.
  - Unsupported encoding: pulse illegal, return to IDLE.
- EXEC: alu_op driven nonzero for this single cycle.
  - At the closing posedge, latch alu_result into wb_data, then go to WB.
- WB: wb_valid=1 holding wb_reg/wb_data stable until wb_valid&&wb_ready, then go to IDLE.
  - If the destination is register 0, skip WB and go straight to IDLE.

R-type (opcode 0) funct -> alu_op:
- 0x20 ADD -> 0001; 0x21 ADDU -> 1010; 0x22 SUB -> 0010; 0x23 SUBU -> 1011
- 0x24 AND -> 0011; 0x25 OR -> 0100; 0x27 NOR -> 0101; 0x2A SLT -> 0110
- 0x00 SLL -> 0111; 0x02 SRL -> 1000; 0x03 SRA -> 1001
- Any other funct is illegal.

Operands and destination:
- alu_shamt = instr[10:6] for shifts, 0 otherwise.
- R-type destination = rd (instr[15:11]).

## Timing
- Accept edge T0 -> DECODE T1 -> EXEC T2 -> wb_valid high from T3; minimum 3 cycles accept-to-wb_valid.
- Next instr_ready no earlier than the cycle after the write-back handshake.
- Throughput is one instruction per 4 cycles when wb_ready stays high.
- wb_valid, once asserted, holds until accepted; wb_data never changes while wb_valid=1.
- Reset in any state: next state IDLE; the in-flight instruction is dropped with no write-back.
- Reset values:
  - instr_ready=1 after the reset edge
  - alu_op=0000; alu_rs, alu_rt, alu_shamt=0
  - wb_valid=0, wb_reg=0, wb_data=0
  - illegal=0, branch_taken=0

## Configuration
Macro ALU_CTRL_IMM_EN.

Defined — I-type support:
- ADDI 0x08 -> 0001, sign-extended immediate
- SLTI 0x0A -> 0110, sign-extended immediate
- ANDI 0x0C -> 0011, zero-extended immediate
- ORI 0x0D -> 0100, zero-extended immediate
- For all of the above, the immediate drives alu_rt and destination = rt (instr[20:16]).
- BEQ 0x04 -> SUB (0010), no write-back; at end of EXEC, branch_taken pulses for one cycle if alu_zero=1, then go to IDLE.

Undefined:
- Any nonzero opcode is illegal.
- branch_taken is tied 0.

## Structure
- Package alu_ctrl_pkg holds:
  - ALU op encodings (ALUOP_ADD..ALUOP_SRA, ALUOP_NONE=4'b0000)
  - funct and opcode constants
  - FSM state enum
- One sub-module, alu_op_decode: combinational instr -> {alu_op, use_imm, sign_ext, dest_sel, is_branch, legal}.
- The FSM and all datapath registers live in alu_issue_ctrl.

## Test plan
- ADD r3=r1+r2, rs_data=5, rt_data=0xFFFFFFFE, wb_ready=1 -> alu_op=0001 in EXEC only; wb_valid at T3; wb_reg=3, wb_data=3.
- SRA rd=4, rt_data=0x80000000, shamt=4 -> alu_op=1001, alu_shamt=4, wb_data=0xF8000000.
- funct 0x3F -> illegal pulses one cycle, no wb_valid, instr_ready back high 2 cycles after accept.
- SUB with wb_ready=0 for 5 cycles -> wb_valid and wb_data stable for all 5; handshake completes, then IDLE.
- reset asserted during EXEC -> next cycle in IDLE: alu_op=0000, wb_valid=0, no write-back.
- With ALU_CTRL_IMM_EN:
  - ADDI imm=0xFFFF, rs_data=1 -> alu_rt=0xFFFFFFFF, wb_data=0.
  - BEQ with equal operands -> branch_taken pulses once, no wb_valid.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: ALU op codes, MIPS
// opcode/funct constants, destination select and the controller FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] ALUOP_NONE = 4'b0000;
  localparam logic [3:0] ALUOP_ADD  = 4'b0001;
  localparam logic [3:0] ALUOP_SUB  = 4'b0010;
  localparam logic [3:0] ALUOP_AND  = 4'b0011;
  localparam logic [3:0] ALUOP_OR   = 4'b0100;
  localparam logic [3:0] ALUOP_NOR  = 4'b0101;
  localparam logic [3:0] ALUOP_SLT  = 4'b0110;
  localparam logic [3:0] ALUOP_SLL  = 4'b0111;
  localparam logic [3:0] ALUOP_SRL  = 4'b1000;
  localparam logic [3:0] ALUOP_SRA  = 4'b1001;
  localparam logic [3:0] ALUOP_ADDU = 4'b1010;
  localparam logic [3:0] ALUOP_SUBU = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Destination register field select
  localparam logic DEST_RD = 1'b0;
  localparam logic DEST_RT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } ctrl_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decoder for the ALU issue controller.
// Optional I-type/BEQ support is enabled by defining ALU_CTRL_IMM_EN.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       use_imm,
  output logic       sign_ext,
  output logic       dest_sel,
  output logic       is_branch,
  output logic       legal
);

  // Map opcode/funct to ALU op and operand/destination controls
  always_comb begin
    alu_op    = ALUOP_NONE;
    use_imm   = 1'b0;
    sign_ext  = 1'b0;
    dest_sel  = DEST_RD;
    is_branch = 1'b0;
    legal     = 1'b0;
    if (opcode == OP_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FN_ADD:  alu_op = ALUOP_ADD;
        FN_ADDU: alu_op = ALUOP_ADDU;
        FN_SUB:  alu_op = ALUOP_SUB;
        FN_SUBU: alu_op = ALUOP_SUBU;
        FN_AND:  alu_op = ALUOP_AND;
        FN_OR:   alu_op = ALUOP_OR;
        FN_NOR:  alu_op = ALUOP_NOR;
        FN_SLT:  alu_op = ALUOP_SLT;
        FN_SLL:  alu_op = ALUOP_SLL;
        FN_SRL:  alu_op = ALUOP_SRL;
        FN_SRA:  alu_op = ALUOP_SRA;
        default: legal  = 1'b0;
      endcase
    end
`ifdef ALU_CTRL_IMM_EN
    else begin
      legal    = 1'b1;
      use_imm  = 1'b1;
      dest_sel = DEST_RT;
      case (opcode)
        OP_ADDI: begin alu_op = ALUOP_ADD; sign_ext = 1'b1; end
        OP_SLTI: begin alu_op = ALUOP_SLT; sign_ext = 1'b1; end
        OP_ANDI: alu_op = ALUOP_AND;
        OP_ORI:  alu_op = ALUOP_OR;
        OP_BEQ: begin
          alu_op    = ALUOP_SUB;
          use_imm   = 1'b0;
          dest_sel  = DEST_RD;
          is_branch = 1'b1;
        end
        default: begin
          legal    = 1'b0;
          use_imm  = 1'b0;
          dest_sel = DEST_RD;
        end
      endcase
    end
`endif
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the negedge-clocked ALU: latches one MIPS
// instruction, decodes it, drives the ALU for one cycle, captures the
// result and offers it to the register-file write port via valid/ready.
// Define ALU_CTRL_IMM_EN to add ADDI/SLTI/ANDI/ORI and BEQ support.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_rs,
  output logic [DATA_W-1:0] alu_rt,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic              branch_taken
);

  ctrl_state_t       state;
  logic [31:0]       instr_q;
  logic [4:0]        dest_q;
  logic              br_q;

  logic [3:0]        dec_op;
  logic              dec_use_imm;
  logic              dec_sign_ext;
  logic              dec_dest_sel;
  logic              dec_branch;
  logic              dec_legal;
  logic              dec_shift;
  logic [DATA_W-1:0] imm_ext;
  logic [4:0]        dec_dest;

  alu_op_decode u_dec (
    .opcode    (instr_q[31:26]),
    .funct     (instr_q[5:0]),
    .alu_op    (dec_op),
    .use_imm   (dec_use_imm),
    .sign_ext  (dec_sign_ext),
    .dest_sel  (dec_dest_sel),
    .is_branch (dec_branch),
    .legal     (dec_legal)
  );

  // Register-file read addresses and decoded operand helpers
  always_comb begin
    rs_addr   = instr_q[25:21];
    rt_addr   = instr_q[20:16];
    dec_shift = (dec_op == ALUOP_SLL) || (dec_op == ALUOP_SRL) || (dec_op == ALUOP_SRA);
    imm_ext   = dec_sign_ext ? {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]}
                             : {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    dec_dest  = (dec_dest_sel == DEST_RT) ? instr_q[20:16] : instr_q[15:11];
  end

`ifndef ALU_CTRL_IMM_EN
  logic unused_zero;
  assign unused_zero = alu_zero;
`endif

  // Issue FSM with all datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      instr_q      <= '0;
      dest_q       <= '0;
      br_q         <= 1'b0;
      instr_ready  <= 1'b1;
      alu_op       <= ALUOP_NONE;
      alu_rs       <= '0;
      alu_rt       <= '0;
      alu_shamt    <= '0;
      wb_valid     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      illegal      <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      illegal      <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!dec_legal) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            alu_op    <= dec_op;
            alu_rs    <= rs_data;
            alu_rt    <= dec_use_imm ? imm_ext : rt_data;
            alu_shamt <= dec_shift ? instr_q[10:6] : 5'd0;
            dest_q    <= dec_dest;
            br_q      <= dec_branch;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_op <= ALUOP_NONE;
          // wb_reg/wb_data are only loaded here so they stay frozen through WB
          if (br_q) begin
`ifdef ALU_CTRL_IMM_EN
            branch_taken <= alu_zero;
`endif
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end else if (dest_q == 5'd0) begin
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wb_data  <= alu_result;
            wb_reg   <= dest_q;
            wb_valid <= 1'b1;
            state    <= ST_WB;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a negedge ALU model
// and a small register-file model. Covers the I-type/BEQ path when
// ALU_CTRL_IMM_EN is defined, otherwise checks those encodings are illegal.
module tb_alu_issue_ctrl;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_rs, alu_rt;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        illegal;
  logic        branch_taken;

  logic [31:0] rf [32];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  alu_issue_ctrl #(.DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_op       (alu_op),
    .alu_rs       (alu_rs),
    .alu_rt       (alu_rt),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .illegal      (illegal),
    .branch_taken (branch_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  // Reference ALU, updating on the falling edge like the real one
  always @(negedge clock) begin
    logic [31:0] r;
    case (alu_op)
      4'b0001, 4'b1010: r = alu_rs + alu_rt;
      4'b0010, 4'b1011: r = alu_rs - alu_rt;
      4'b0011: r = alu_rs & alu_rt;
      4'b0100: r = alu_rs | alu_rt;
      4'b0101: r = ~(alu_rs | alu_rt);
      4'b0110: r = ($signed(alu_rs) < $signed(alu_rt)) ? 32'd1 : 32'd0;
      4'b0111: r = alu_rt << alu_shamt;
      4'b1000: r = alu_rt >> alu_shamt;
      4'b1001: r = $signed(alu_rt) >>> alu_shamt;
      default: r = 32'd0;
    endcase
    alu_result = r;
    alu_zero   = (r == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full issue of one write-back instruction with wb_ready held high
  task automatic run_wb(input string tag, input logic [31:0] ins, input logic [3:0] eop,
                        input logic [31:0] ers, input logic [31:0] ert, input logic [4:0] esh,
                        input logic [4:0] ereg, input logic [31:0] edata);
    check({tag, "_ready"}, instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check({tag, "_dec_ready"}, instr_ready, 0);
    check({tag, "_dec_op"}, alu_op, 0);
    tick();
    check({tag, "_op"}, alu_op, eop);
    check({tag, "_rs"}, alu_rs, ers);
    check({tag, "_rt"}, alu_rt, ert);
    check({tag, "_shamt"}, alu_shamt, esh);
    check({tag, "_exec_wbv"}, wb_valid, 0);
    tick();
    check({tag, "_wb_op"}, alu_op, 0);
    check({tag, "_wbv"}, wb_valid, 1);
    check({tag, "_wbreg"}, wb_reg, ereg);
    check({tag, "_wbdata"}, wb_data, edata);
    tick();
    check({tag, "_done_wbv"}, wb_valid, 0);
    check({tag, "_done_ready"}, instr_ready, 1);
  endtask

  // Instruction expected to be rejected in DECODE
  task automatic run_illegal(input string tag, input logic [31:0] ins);
    instr = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check({tag, "_ill_dec"}, illegal, 0);
    tick();
    check({tag, "_ill_pulse"}, illegal, 1);
    check({tag, "_ill_ready"}, instr_ready, 1);
    check({tag, "_ill_wbv"}, wb_valid, 0);
    tick();
    check({tag, "_ill_clear"}, illegal, 0);
    check({tag, "_ill_wbv2"}, wb_valid, 0);
  endtask

  typedef struct {
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [3:0]  op;
    logic [4:0]  esh;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs = '{
      '{6'h21, 5'd0, 4'b1010, 5'd0, 32'h00000003},
      '{6'h22, 5'd0, 4'b0010, 5'd0, 32'h00000007},
      '{6'h23, 5'd0, 4'b1011, 5'd0, 32'h00000007},
      '{6'h24, 5'd3, 4'b0011, 5'd0, 32'h00000004},
      '{6'h25, 5'd0, 4'b0100, 5'd0, 32'hFFFFFFFF},
      '{6'h27, 5'd0, 4'b0101, 5'd0, 32'h00000000},
      '{6'h2A, 5'd0, 4'b0110, 5'd0, 32'h00000000},
      '{6'h00, 5'd1, 4'b0111, 5'd1, 32'hFFFFFFFC},
      '{6'h02, 5'd4, 4'b1000, 5'd4, 32'h0FFFFFFF}
    };
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1]  = 32'd5;
    rf[2]  = 32'hFFFFFFFE;
    rf[5]  = 32'h80000000;
    rf[11] = 32'd1;
    alu_result  = 32'd0;
    alu_zero    = 1'b1;
    instr       = 32'd0;
    instr_valid = 1'b0;
    wb_ready    = 1'b1;
    reset       = 1'b1;
    tick();
    tick();

    // Reset values
    check("rst_ready", instr_ready, 1);
    check("rst_op", alu_op, 0);
    check("rst_rs", alu_rs, 0);
    check("rst_rt", alu_rt, 0);
    check("rst_shamt", alu_shamt, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbreg", wb_reg, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_ill", illegal, 0);
    check("rst_br", branch_taken, 0);
    reset = 1'b0;
    tick();

    // ADD r3 = r1 + r2 -> 3, with read-address check in DECODE
    instr = 32'h00221820;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("add_rsaddr", rs_addr, 1);
    check("add_rtaddr", rt_addr, 2);
    tick();
    check("add_op", alu_op, 4'b0001);
    tick();
    check("add_op_off", alu_op, 0);
    check("add_wbv", wb_valid, 1);
    check("add_wbreg", wb_reg, 3);
    check("add_wbdata", wb_data, 3);
    tick();
    check("add_ready", instr_ready, 1);
    check("add_wbv_done", wb_valid, 0);

    // SRA rd=4, rt=r5, shamt=4
    run_wb("sra", 32'h00052103, 4'b1001, 32'd0, 32'h80000000, 5'd4, 5'd4, 32'hF8000000);

    // Remaining R-type ops: rs=r1 (5), rt=r2 (-2), rd=7
    foreach (vecs[i])
      run_wb($sformatf("rt%0d", i), {6'h00, 5'd1, 5'd2, 5'd7, vecs[i].sh, vecs[i].fn},
             vecs[i].op, 32'd5, 32'hFFFFFFFE, vecs[i].esh, 5'd7, vecs[i].data);

    // SLT true case: -2 < 5
    run_wb("slt1", 32'h0041382A, 4'b0110, 32'hFFFFFFFE, 32'd5, 5'd0, 5'd7, 32'd1);

    // Unsupported funct
    run_illegal("fn3f", 32'h0022183F);

    // SUB with write port stalled for 5 cycles
    wb_ready = 1'b0;
    instr = 32'h00224022;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_wbv", i), wb_valid, 1);
      check($sformatf("stall%0d_data", i), wb_data, 7);
      check($sformatf("stall%0d_reg", i), wb_reg, 8);
      check($sformatf("stall%0d_ready", i), instr_ready, 0);
      tick();
    end
    wb_ready = 1'b1;
    check("stall_hs_wbv", wb_valid, 1);
    tick();
    check("stall_done_wbv", wb_valid, 0);
    check("stall_done_ready", instr_ready, 1);

    // Destination r0: no write-back
    instr = 32'h00220020;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("r0_wbv", wb_valid, 0);
    check("r0_ready", instr_ready, 1);
    tick();

    // Reset during EXEC drops the instruction
    instr = 32'h00224820;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("rexec_op", alu_op, 4'b0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rexec_idle_op", alu_op, 0);
    check("rexec_idle_wbv", wb_valid, 0);
    check("rexec_idle_ready", instr_ready, 1);
    check("rexec_wbdata", wb_data, 0);
    tick();
    tick();
    check("rexec_later_wbv", wb_valid, 0);

`ifdef ALU_CTRL_IMM_EN
    // ADDI rt=10, rs=r11 (1), imm=0xFFFF -> 0
    run_wb("addi", 32'h216AFFFF, 4'b0001, 32'd1, 32'hFFFFFFFF, 5'd0, 5'd10, 32'd0);
    // ANDI rt=12, rs=r1 (5), imm=0xFFFF zero-extended -> 5
    run_wb("andi", 32'h302CFFFF, 4'b0011, 32'd5, 32'h0000FFFF, 5'd0, 5'd12, 32'd5);

    // BEQ r1,r1 -> taken
    instr = 32'h10210000;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("beq_op", alu_op, 4'b0010);
    tick();
    check("beq_taken", branch_taken, 1);
    check("beq_wbv", wb_valid, 0);
    check("beq_ready", instr_ready, 1);
    tick();
    check("beq_pulse_end", branch_taken, 0);

    // BEQ r1,r2 -> not taken
    instr = 32'h10220000;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("bne_taken", branch_taken, 0);
    check("bne_wbv", wb_valid, 0);
    tick();
`else
    // Without immediate support every nonzero opcode is rejected
    run_illegal("addi", 32'h216AFFFF);
    run_illegal("beq", 32'h10210000);
    check("nobr_taken", branch_taken, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    $fatal(1);
  end

endmodule
